// File: rtl/regfile_pkg.sv
// Shared widths, FSM state encoding and payload structs for the RV32I register file.
package regfile_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = $clog2(NREGS);

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Debug access request as presented by the requester
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } dbg_req_t;

    // Resolved request onto the single array write port
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } wr_port_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks x1..x31 writing zero, then releases the core.
module regfile_clr_seq
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leave CLEAR on the edge that clears the last register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_REG) begin
                state_d = RF_RUN;
            end
        end
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_we   = busy && !rst;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit RV32I register file with debug access port and post-reset clear sweep.
// Optional write-to-read forwarding on the core read ports when REGFILE_BYPASS_EN is defined.
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [XLEN-1:0]   rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [XLEN-1:0]   dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [XLEN-1:0]   dbg_rdata_o,
    output logic              busy_o
);

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clr_seq u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy_o = busy;

    logic [XLEN-1:0] regs [NREGS];

    dbg_req_t        dbg;
    logic            core_we_c;
    logic            dbg_accept_c;
    logic            dbg_we_c;
    logic [XLEN-1:0] dbg_rdata_c;
    wr_port_t        wr_c;

    assign dbg = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};

    assign core_we_c    = !busy && !rst && we_i && (waddr_i != ZERO_REG);
    // Core write wins the single write port; a debug write waits it out
    assign dbg_accept_c = !busy && !rst && dbg_req_i && !dbg_ack_o && !(dbg.we && we_i);
    assign dbg_we_c     = dbg_accept_c && dbg.we && (dbg.addr != ZERO_REG);
    assign dbg_rdata_c  = (dbg.addr == ZERO_REG) ? '0 : regs[dbg.addr];

    always_comb begin
        wr_c = '0;
        if (clr_we) begin
            wr_c = '{en: 1'b1, addr: clr_addr, data: '0};
        end else if (core_we_c) begin
            wr_c = '{en: 1'b1, addr: waddr_i, data: wdata_i};
        end else if (dbg_we_c) begin
            wr_c = '{en: 1'b1, addr: dbg.addr, data: dbg.wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c.en) begin
            regs[wr_c.addr] <= wr_c.data;
        end
    end

    // Core read ports; forced to zero while the sweep owns the array
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (!busy) begin
            rdata1_o = (raddr1_i == ZERO_REG) ? '0 : regs[raddr1_i];
            rdata2_o = (raddr2_i == ZERO_REG) ? '0 : regs[raddr2_i];
`ifdef REGFILE_BYPASS_EN
            if (core_we_c && (waddr_i == raddr1_i)) begin
                rdata1_o = wdata_i;
            end
            if (core_we_c && (waddr_i == raddr2_i)) begin
                rdata2_o = wdata_i;
            end
`endif
        end
    end

    // Debug response captures the pre-write register value
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= '0;
        end else begin
            dbg_ack_o <= dbg_accept_c;
            if (dbg_accept_c) begin
                dbg_rdata_o <= dbg_rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset sweep, writes, x0, debug port, reset mid-sweep.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr1_i, raddr2_i, waddr_i, dbg_addr_i;
    logic [31:0] rdata1_o, rdata2_o, wdata_i, dbg_wdata_i, dbg_rdata_o;
    logic        we_i, dbg_req_i, dbg_we_i, dbg_ack_o, busy_o;

    int checks = 0;
    int passed = 0;

    regfile dut (
        .clk         (clk),
        .rst         (rst),
        .raddr1_i    (raddr1_i),
        .rdata1_o    (rdata1_o),
        .raddr2_i    (raddr2_i),
        .rdata2_o    (rdata2_o),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_ack_o   (dbg_ack_o),
        .dbg_rdata_o (dbg_rdata_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (busy_o !== 1'b1 || dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h0)
            $display("FAIL reset_state: busy=%b ack=%b rdata=%h, want busy=1 ack=0 rdata=0",
                     busy_o, dbg_ack_o, dbg_rdata_o);
        else passed++;
        rst = 1'b0;
        raddr1_i = 5'd3;
        #1;
        checks++;
        if (rdata1_o !== 32'h0) $display("FAIL clear_read_zero: rdata1=%h want 0", rdata1_o);
        else passed++;
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            n++;
            step();
        end
        checks++;
        if (n !== 31) $display("FAIL busy_cycles: got %0d want 31", n);
        else passed++;
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            raddr1_i = 5'(i);
            #1;
            if (rdata1_o !== 32'h0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL swept_zero: %0d regs nonzero, want 0", bad);
        else passed++;
    endtask

    task automatic test_write_bypass();
        we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF; raddr1_i = 5'd5;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rdata1_o !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle: %h want deadbeef", rdata1_o);
        else passed++;
`else
        if (rdata1_o !== 32'h0) $display("FAIL no_bypass_same_cycle: %h want 0", rdata1_o);
        else passed++;
`endif
        step();
        we_i = 1'b0;
        #1;
        checks++;
        if (rdata1_o !== 32'hDEADBEEF) $display("FAIL write_next_cycle: %h want deadbeef", rdata1_o);
        else passed++;
    endtask

    task automatic test_x0();
        we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h1234; raddr1_i = 5'd0; raddr2_i = 5'd0;
        #1;
        checks++;
        if (rdata1_o !== 32'h0) $display("FAIL x0_same_cycle: %h want 0", rdata1_o);
        else passed++;
        step();
        we_i = 1'b0;
        #1;
        checks++;
        if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0)
            $display("FAIL x0_after_write: r1=%h r2=%h want 0", rdata1_o, rdata2_o);
        else passed++;
    endtask

    task automatic test_dbg_read();
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
        step();
        checks++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'hDEADBEEF)
            $display("FAIL dbg_read: ack=%b rdata=%h want ack=1 rdata=deadbeef", dbg_ack_o, dbg_rdata_o);
        else passed++;
        // request held: cycle after ack must not re-accept
        step();
        checks++;
        if (dbg_ack_o !== 1'b0) $display("FAIL dbg_ack_one_cycle: ack=%b want 0", dbg_ack_o);
        else passed++;
        dbg_req_i = 1'b0;
        step();
    endtask

    task automatic test_dbg_write_stall();
        int acks;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'hA5A5A5A5;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h30 + 32'(i);
            step();
            if (dbg_ack_o === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) $display("FAIL dbg_write_stall: %0d acks while we_i=1 want 0", acks);
        else passed++;
        we_i = 1'b0;
        step();
        checks++;
        if (dbg_ack_o !== 1'b1) $display("FAIL dbg_write_ack: ack=%b want 1", dbg_ack_o);
        else passed++;
        dbg_req_i = 1'b0; raddr2_i = 5'd7; raddr1_i = 5'd3;
        #1;
        checks++;
        if (rdata2_o !== 32'hA5A5A5A5 || rdata1_o !== 32'h32)
            $display("FAIL dbg_write_data: x7=%h x3=%h want a5a5a5a5 and 32", rdata2_o, rdata1_o);
        else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int early_ack;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (11) step();
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        early_ack = 0;
        while (busy_o === 1'b1 && n < 100) begin
            if (dbg_ack_o === 1'b1) early_ack++;
            n++;
            step();
        end
        checks++;
        if (n !== 31) $display("FAIL restart_busy_cycles: got %0d want 31", n);
        else passed++;
        checks++;
        if (early_ack !== 0) $display("FAIL ack_during_clear: %0d acks want 0", early_ack);
        else passed++;
        step();
        checks++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h0)
            $display("FAIL dbg_after_restart: ack=%b rdata=%h want ack=1 rdata=0", dbg_ack_o, dbg_rdata_o);
        else passed++;
        dbg_req_i = 1'b0;
        step();
    endtask

    task automatic test_same_cycle();
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h99;
        step();
        wdata_i = 32'h1;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd9;
        step();
        checks++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h99)
            $display("FAIL same_cycle_dbg: ack=%b rdata=%h want ack=1 rdata=99", dbg_ack_o, dbg_rdata_o);
        else passed++;
        we_i = 1'b0; dbg_req_i = 1'b0; raddr1_i = 5'd9;
        #1;
        checks++;
        if (rdata1_o !== 32'h1) $display("FAIL same_cycle_core: x9=%h want 1", rdata1_o);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        raddr1_i = '0; raddr2_i = '0;
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        test_reset();
        test_write_bypass();
        test_x0();
        test_dbg_read();
        test_dbg_write_stall();
        test_reset_mid_sweep();
        test_same_cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
